// File: rtl/shift_ctrl.sv
// Command sequencer for an 8-bit universal shift register: load, shift N, capture, respond.
// Optional rotate fill from the outgoing bit when SHIFT_ROTATE_EN is defined.
module shift_ctrl #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_data,
    input  logic             req_dir,
    input  logic [CNT_W-1:0] req_amt,
    input  logic             req_fill,
    input  logic             req_rot,
    output logic [WIDTH-1:0] sh_In,
    output logic [1:0]       sh_S,
    output logic             sh_IL,
    output logic             sh_IR,
    input  logic [WIDTH-1:0] sh_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             busy
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] SHIFT = 3'd2;
    localparam logic [2:0] HOLD  = 3'd3;
    localparam logic [2:0] RESP  = 3'd4;

    localparam logic [CNT_W-1:0] AMT_MAX = CNT_W'(WIDTH);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] amt_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] res_q;
    logic             dir_q;
    logic             fill_q;
    logic             rot_q;
    logic             accept;
    logic [CNT_W-1:0] amt_eff;
    logic             fill_bit;

    assign accept  = (state_q == IDLE) && req_valid;
    assign amt_eff = (req_amt > AMT_MAX) ? AMT_MAX : req_amt;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_valid) state_d = LOAD;
            end
            LOAD: begin
                cnt_d   = amt_q;
                state_d = (amt_q != '0) ? SHIFT : HOLD;
            end
            SHIFT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = HOLD;
            end
            HOLD: begin
                state_d = RESP;
            end
            RESP: begin
                if (res_ready) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            amt_q   <= '0;
            data_q  <= '0;
            res_q   <= '0;
            dir_q   <= 1'b0;
            fill_q  <= 1'b0;
            rot_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                data_q <= req_data;
                dir_q  <= req_dir;
                fill_q <= req_fill;
                amt_q  <= amt_eff;
`ifdef SHIFT_ROTATE_EN
                rot_q  <= req_rot;
`else
                rot_q  <= 1'b0;
`endif
            end
            // The last shift has landed in the register by the end of HOLD.
            if (state_q == HOLD) res_q <= sh_out;
        end
    end

`ifdef SHIFT_ROTATE_EN
    assign fill_bit = rot_q ? (dir_q ? sh_out[WIDTH-1] : sh_out[0]) : fill_q;
`else
    logic unused_rot;
    assign unused_rot = req_rot ^ rot_q;
    assign fill_bit   = fill_q;
`endif

    always_comb begin
        sh_S  = 2'b00;
        sh_In = '0;
        sh_IL = 1'b0;
        sh_IR = 1'b0;
        case (state_q)
            LOAD: begin
                sh_S  = 2'b11;
                sh_In = data_q;
            end
            SHIFT: begin
                sh_S  = dir_q ? 2'b10 : 2'b01;
                sh_IL = fill_bit;
                sh_IR = fill_bit;
            end
            default: begin
                sh_S = 2'b00;
            end
        endcase
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign res_valid = (state_q == RESP);
    assign res_data  = res_q;

endmodule

// File: tb/tb_shift_ctrl.sv
// Directed bench for shift_ctrl with a behavioural universal shift register in the loop.
// Expected rotate results follow SHIFT_ROTATE_EN when it is defined for the build.
module tb_shift_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_data;
    logic       req_dir;
    logic [3:0] req_amt;
    logic       req_fill;
    logic       req_rot;
    logic [7:0] sh_In;
    logic [1:0] sh_S;
    logic       sh_IL;
    logic       sh_IR;
    logic [7:0] sh_out;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic       busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    shift_ctrl #(.WIDTH(8), .CNT_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_dir   (req_dir),
        .req_amt   (req_amt),
        .req_fill  (req_fill),
        .req_rot   (req_rot),
        .sh_In     (sh_In),
        .sh_S      (sh_S),
        .sh_IL     (sh_IL),
        .sh_IR     (sh_IR),
        .sh_out    (sh_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .busy      (busy)
    );

    // Downstream universal shift register.
    logic [7:0] sr = 8'h00;
    always_ff @(posedge clk) begin
        case (sh_S)
            2'b01:   sr <= {sh_IR, sr[7:1]};
            2'b10:   sr <= {sr[6:0], sh_IL};
            2'b11:   sr <= sh_In;
            default: sr <= sr;
        endcase
    end
    assign sh_out = sr;

    typedef struct {
        logic [7:0] data;
        logic       dir;
        logic [3:0] amt;
        logic       fill;
        logic       rot;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int         sh_cnt;
        int         bad;
        int         lat;
        int         ae;
        logic [1:0] exp_s;
        logic       rot_on;
        ae    = (v.amt > 4'd8) ? 8 : int'(v.amt);
        exp_s = v.dir ? 2'b10 : 2'b01;
`ifdef SHIFT_ROTATE_EN
        rot_on = v.rot;
`else
        rot_on = 1'b0;
`endif
        @(negedge clk);
        req_valid = 1'b1;
        req_data  = v.data;
        req_dir   = v.dir;
        req_amt   = v.amt;
        req_fill  = v.fill;
        req_rot   = v.rot;
        res_ready = 1'b0;
        check("idle_ready", {31'b0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        check("load_S", {30'b0, sh_S}, 32'd3);
        check("load_In", {24'b0, sh_In}, {24'b0, v.data});
        sh_cnt = 0;
        bad    = 0;
        lat    = -1;
        for (int j = 1; j < 30; j++) begin
            @(negedge clk);
            if (res_valid) begin
                lat = j;
                break;
            end
            if (sh_S == exp_s) begin
                sh_cnt++;
                if (sh_In !== 8'h00) bad++;
                if (!rot_on && (sh_IL !== v.fill || sh_IR !== v.fill)) bad++;
            end else if (sh_S != 2'b00 || sh_IL || sh_IR || sh_In != 8'h00) begin
                bad++;
            end
        end
        check("shift_cycles", sh_cnt, ae);
        check("latency", lat, ae + 2);
        check("seq_errors", bad, 0);
        check("res_data", {24'b0, res_data}, {24'b0, v.exp});
        check("resp_busy", {30'b0, busy, req_ready}, 32'd2);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("after_hs", {30'b0, res_valid, req_ready}, 32'd1);
    endtask

    task automatic wait_res(input string name);
        int n;
        n = 0;
        while (!res_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'b0, res_valid}, 32'd1);
    endtask

    initial begin
        vecs[0] = '{8'hA5, 1'b0, 4'd1,  1'b0, 1'b0, 8'h52};
        vecs[1] = '{8'h81, 1'b1, 4'd3,  1'b1, 1'b0, 8'h0F};
        vecs[2] = '{8'h3C, 1'b0, 4'd0,  1'b0, 1'b0, 8'h3C};
        vecs[3] = '{8'hFF, 1'b0, 4'd12, 1'b0, 1'b0, 8'h00};
        vecs[4] = '{8'h0F, 1'b0, 4'd15, 1'b1, 1'b0, 8'hFF};
        vecs[5] = '{8'h00, 1'b0, 4'd2,  1'b1, 1'b0, 8'hC0};
`ifdef SHIFT_ROTATE_EN
        vecs[6] = '{8'h81, 1'b0, 4'd1,  1'b0, 1'b1, 8'hC0};
`else
        vecs[6] = '{8'h81, 1'b0, 4'd1,  1'b0, 1'b1, 8'h40};
`endif

        reset     = 1'b0;
        req_valid = 1'b0;
        req_data  = 8'h00;
        req_dir   = 1'b0;
        req_amt   = 4'd0;
        req_fill  = 1'b0;
        req_rot   = 1'b0;
        res_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_S", {30'b0, sh_S}, 32'd0);
        check("rst_In", {24'b0, sh_In}, 32'd0);
        check("rst_ILIR", {30'b0, sh_IL, sh_IR}, 32'd0);
        check("rst_res", {23'b0, res_valid, res_data}, 32'd0);
        check("rst_busy_ready", {30'b0, busy, req_ready}, 32'd1);
        reset = 1'b1;

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Response stalled while a second request waits.
        @(negedge clk);
        req_valid = 1'b1;
        req_data  = 8'hA5;
        req_dir   = 1'b0;
        req_amt   = 4'd1;
        req_fill  = 1'b0;
        req_rot   = 1'b0;
        @(negedge clk);
        req_data = 8'h3C;
        req_amt  = 4'd0;
        wait_res("stall_res_valid");
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_valid", {31'b0, res_valid}, 32'd1);
            check("stall_data", {24'b0, res_data}, 32'h52);
            check("stall_ready", {31'b0, req_ready}, 32'd0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("stall_hs", {30'b0, res_valid, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        check("next_load", {22'b0, sh_S, sh_In}, {22'b0, 2'b11, 8'h3C});
        wait_res("next_res_valid");
        check("next_data", {24'b0, res_data}, 32'h3C);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;

        // Reset during the second shift cycle aborts the request.
        @(negedge clk);
        req_valid = 1'b1;
        req_data  = 8'h55;
        req_amt   = 4'd4;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_in_shift", {30'b0, sh_S}, 32'd1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("abort_S", {30'b0, sh_S}, 32'd0);
        check("abort_flags", {29'b0, busy, res_valid, req_ready}, 32'd1);
        check("abort_data", {24'b0, res_data}, 32'd0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("abort_no_res", {30'b0, res_valid, busy}, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/shift_ctrl.md
Name: shift_ctrl

Overview:
Command sequencer that sits directly upstream of the 8-bit universal shift register and drives its In/S/IL/IR inputs. It accepts a shift request over a valid/ready handshake, issues one parallel-load cycle followed by N shift cycles, and captures the shift register's output. It then returns the result over a valid/ready handshake. One request is in flight at a time.

Parameters:
WIDTH, 8, data width; matches the shift register width.
CNT_W, 4, width of the shift-amount field; must hold the value WIDTH.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  synchronous reset, active-low; sampled on the rising edge of clk.
req_valid  in  1  request present.
req_ready  out  1  high exactly when state is IDLE.
req_data  in  WIDTH  value to load.
req_dir  in  1  shift direction: 0 = right, 1 = left.
req_amt  in  CNT_W  number of shift cycles.
req_fill  in  1  serial fill bit.
req_rot  in  1  rotate request; used only under SHIFT_ROTATE_EN.
sh_In  out  WIDTH  to shift register In.
sh_S  out  2  to shift register S.
sh_IL  out  1  to shift register IL.
sh_IR  out  1  to shift register IR.
sh_out  in  WIDTH  from shift register out.
res_valid  out  1  result available.
res_ready  in  1  result consumer ready.
res_data  out  WIDTH  captured result.
busy  out  1  high in any state other than IDLE.

Behaviour:
- Shift register S encoding:
  - 00: hold.
  - 01: shift right; IR enters the MSB.
  - 10: shift left; IL enters the LSB.
  - 11: parallel load of In.
  - The shift register updates on the rising edge of clk.
- Reset (reset low at a rising edge), required values after that edge:
  - state = IDLE.
  - sh_S = 00, sh_In = 0, sh_IL = 0, sh_IR = 0.
  - res_valid = 0, res_data = 0, busy = 0, req_ready = 1.
- Reset asserted mid-operation aborts the operation immediately. No response is produced and latched request fields are cleared.
- Request latch:
  - A request is accepted at a rising edge where req_valid = 1 and state = IDLE.
  - data, dir, fill and rot are latched at that edge.
  - amt_eff = min(req_amt, WIDTH) is also latched.
- States and transitions:
  - IDLE: sh_S = 00. On acceptance, go to LOAD.
  - LOAD (1 cycle): sh_S = 11, sh_In = latched data. Next state is SHIFT if amt_eff > 0, otherwise HOLD.
  - SHIFT: lasts exactly amt_eff cycles.
    - sh_S = 01 when dir = 0, 10 when dir = 1.
    - The down-counter loads amt_eff on entry and decrements each cycle.
    - Exit to HOLD after the cycle in which the count reaches 1.
  - HOLD (1 cycle): sh_S = 00. res_data <= sh_out at the exit edge; go to RESP.
  - RESP: sh_S = 00, res_valid = 1. res_data and res_valid stay stable until res_ready = 1 at an edge. Then res_valid <= 0 and the block returns to IDLE.
- Outputs outside their active state:
  - sh_In = 0 outside LOAD.
  - sh_IL and sh_IR = latched fill during SHIFT, 0 otherwise. Both are driven with the same value.
- Latency: for acceptance edge E0, res_valid is high after edge E0 + amt_eff + 2.
- Throughput: a new request may be accepted no earlier than the edge after the RESP handshake. Back-to-back issue from RESP directly into LOAD is not supported.
- req_valid seen while busy is ignored and is not stored.
- Out-of-range amounts: req_amt > WIDTH saturates to WIDTH, i.e. WIDTH shift cycles.

Optional Feature:
SHIFT_ROTATE_EN
- Defined, with latched rot = 1: the fill is the bit being shifted out, forming a rotate.
  - Right shift: sh_IR = sh_out[0].
  - Left shift: sh_IL = sh_out[WIDTH-1].
  - Taken combinationally from sh_out during SHIFT.
- Defined, with rot = 0: the latched fill is used.
- Not defined: the req_rot port still exists but is ignored, and the fill is always the latched req_fill.

Test Plan:
1. req_data=0xA5, dir=0, amt=1, fill=0 -> sh_S sequence 11,01,00. res_data=0x52 with res_valid high after edge E0+3.
2. req_data=0x81, dir=1, amt=3, fill=1 -> three cycles of sh_S=10 with sh_IL=1. res_data=0x0F.
3. amt=0, req_data=0x3C -> no SHIFT cycles, res_data=0x3C at E0+2. amt=12, req_data=0xFF, dir=0, fill=0 -> exactly 8 shift cycles, res_data=0x00.
4. Hold req_valid=1 and res_ready=0 for 5 cycles after a result:
   - res_valid and res_data remain stable.
   - req_ready stays 0 and no second request is accepted.
   - After res_ready=1, the next request is accepted on the following edge.
5. Pull reset low during the second SHIFT cycle of an amt=4 request -> after that edge: state IDLE, sh_S=00, busy=0, res_valid=0, req_ready=1. No result is produced.
6. SHIFT_ROTATE_EN defined, req_data=0x81, dir=0, amt=1, rot=1 -> res_data=0xC0. Same stimulus without the macro and fill=0 -> res_data=0x40.
